// File: rtl/line_mem_arbiter.sv
// Two-way arbiter for the 256-bit cacheline memory port: demand (read/write) beats prefetch (read),
// with a bounded defer counter for prefetch progress and demand-read forwarding from an in-flight prefetch.
module line_mem_arbiter #(
   parameter int unsigned MAX_DEFER = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         dmd_read,
   input  logic         dmd_write,
   input  logic [31:0]  dmd_address,
   input  logic [255:0] dmd_wdata,
   output logic [255:0] dmd_rdata,
   output logic         dmd_resp,
   input  logic         pf_read,
   input  logic [31:0]  pf_address,
   output logic [255:0] pf_rdata,
   output logic         pf_resp,
   output logic         mem_read,
   output logic         mem_write,
   output logic [31:0]  mem_address,
   output logic [255:0] mem_wdata,
   input  logic [255:0] mem_rdata,
   input  logic         mem_resp,
   output logic         pf_forwarded,
   output logic [1:0]   dbg_state_o,
   output logic [3:0]   dbg_defer_cnt_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DMD  = 2'd1,
      ST_PF   = 2'd2
   } state_t;

   localparam logic [3:0] MAX_DEFER_C = MAX_DEFER[3:0];

   state_t        state_q, state_d;
   logic [3:0]    defer_q, defer_d;
   logic          mem_read_q, mem_read_d;
   logic          mem_write_q, mem_write_d;
   logic [26:0]   line_q, line_d;
   logic [255:0]  wdata_q, wdata_d;

   logic          dmd_any;
   logic          pf_forced;
   logic          grant_pf;
   logic          grant_dmd;
   logic          fwd_hit;
   logic          unused_addr_bits;

   assign unused_addr_bits = ^{dmd_address[4:0], pf_address[4:0]};

   // Requests are level-held until their resp pulse; the arbiter only looks at them in IDLE,
   // and a resp pulse exists only in a cycle where mem_resp is high for the current owner.
   assign dmd_any   = dmd_read | dmd_write;
   assign pf_forced = pf_read && (defer_q == MAX_DEFER_C);
   assign grant_pf  = (state_q == ST_IDLE) && pf_read && (pf_forced || !dmd_any);
   assign grant_dmd = (state_q == ST_IDLE) && dmd_any && !pf_forced;
   assign fwd_hit   = (state_q == ST_PF) && mem_resp && dmd_read && !dmd_write
                      && (dmd_address[31:5] == line_q);

   always_comb begin
      state_d     = state_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      line_d      = line_q;
      wdata_d     = wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_pf) begin
               state_d     = ST_PF;
               line_d      = pf_address[31:5];
               mem_read_d  = 1'b1;
               mem_write_d = 1'b0;
            end else if (grant_dmd) begin
               // A simultaneous read+write request is treated as a write.
               state_d     = ST_DMD;
               line_d      = dmd_address[31:5];
               mem_read_d  = !dmd_write;
               mem_write_d = dmd_write;
               if (dmd_write) begin
                  wdata_d = dmd_wdata;
               end
            end
         end
         ST_DMD, ST_PF: begin
            if (mem_resp) begin
               state_d     = ST_IDLE;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
         end
      endcase
   end

   always_comb begin
      defer_d = defer_q;
      if (!pf_read || grant_pf) begin
         defer_d = 4'd0;
      end else if (grant_dmd && (defer_q != MAX_DEFER_C)) begin
         defer_d = defer_q + 4'd1;
      end
   end

   // Completion outputs follow mem_resp combinationally for the current owner only.
   always_comb begin
      dmd_resp     = 1'b0;
      pf_resp      = 1'b0;
      dmd_rdata    = '0;
      pf_rdata     = '0;
      pf_forwarded = 1'b0;
      if (!rst && mem_resp) begin
         if (state_q == ST_DMD) begin
            dmd_resp = 1'b1;
            if (mem_read_q) begin
               dmd_rdata = mem_rdata;
            end
         end else if (state_q == ST_PF) begin
            pf_resp  = 1'b1;
            pf_rdata = mem_rdata;
            if (fwd_hit) begin
               dmd_resp     = 1'b1;
               dmd_rdata    = mem_rdata;
               pf_forwarded = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         defer_q     <= 4'd0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         line_q      <= '0;
         wdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         defer_q     <= defer_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         line_q      <= line_d;
         wdata_q     <= wdata_d;
      end
   end

   assign mem_read        = mem_read_q;
   assign mem_write       = mem_write_q;
   assign mem_address     = {line_q, 5'b0};
   assign mem_wdata       = wdata_q;
   assign dbg_state_o     = state_q;
   assign dbg_defer_cnt_o = defer_q;

endmodule

// File: tb/tb_line_mem_arbiter.sv
// Directed bench for line_mem_arbiter: a latency-programmable memory model plus hand-computed
// expectations for grant order, starvation, forwarding, write no-forward, spurious resp and reset.
module tb_line_mem_arbiter;

   localparam int         MAX_DEFER = 4;
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_DMD     = 2'd1;
   localparam logic [1:0] S_PF      = 2'd2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         dmd_read = 1'b0;
   logic         dmd_write = 1'b0;
   logic [31:0]  dmd_address = '0;
   logic [255:0] dmd_wdata = '0;
   logic [255:0] dmd_rdata;
   logic         dmd_resp;
   logic         pf_read = 1'b0;
   logic [31:0]  pf_address = '0;
   logic [255:0] pf_rdata;
   logic         pf_resp;
   logic         mem_read;
   logic         mem_write;
   logic [31:0]  mem_address;
   logic [255:0] mem_wdata;
   logic [255:0] mem_rdata = '0;
   logic         mem_resp = 1'b0;
   logic         pf_forwarded;
   logic [1:0]   dbg_state;
   logic [3:0]   dbg_defer;

   int n_cmp = 0;
   int n_err = 0;
   int lat = 3;
   int mem_cnt = 0;
   int mem_accesses = 0;
   logic [255:0] exp_q[$];

   always #5 clk = ~clk;

   line_mem_arbiter #(.MAX_DEFER(MAX_DEFER)) dut (
      .clk(clk), .rst(rst),
      .dmd_read(dmd_read), .dmd_write(dmd_write), .dmd_address(dmd_address),
      .dmd_wdata(dmd_wdata), .dmd_rdata(dmd_rdata), .dmd_resp(dmd_resp),
      .pf_read(pf_read), .pf_address(pf_address), .pf_rdata(pf_rdata), .pf_resp(pf_resp),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .pf_forwarded(pf_forwarded), .dbg_state_o(dbg_state), .dbg_defer_cnt_o(dbg_defer)
   );

   function automatic logic [255:0] line_data(input logic [31:0] a);
      return {8{a ^ 32'h5A5A_0000}};
   endfunction

   // Memory: resp pulses once 'lat' cycles after the first strobe cycle.
   always begin
      @(posedge clk);
      #1;
      if (mem_resp) begin
         mem_resp = 1'b0;
         mem_cnt  = 0;
      end else if (mem_read || mem_write) begin
         mem_cnt++;
         if (mem_cnt == 1) mem_accesses++;
         if (mem_cnt > lat) begin
            mem_resp  = 1'b1;
            mem_rdata = line_data(mem_address);
         end
      end else begin
         mem_cnt = 0;
      end
   end

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic wait_resp(input string tag, input bit pf_side, output int n);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         sample();
         n = i + 1;
         if (pf_side ? pf_resp : dmd_resp) return;
      end
      check_eq({tag, " timeout"}, 256'(pf_side ? pf_resp : dmd_resp), 256'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int acc0;
      logic [255:0] wd;

      // Reset
      repeat (3) step();
      sample();
      check_eq("rst mem_read", 256'(mem_read), 256'd0);
      check_eq("rst mem_write", 256'(mem_write), 256'd0);
      check_eq("rst state", 256'(dbg_state), 256'(S_IDLE));
      check_eq("rst defer", 256'(dbg_defer), 256'd0);
      check_eq("rst mem_address", 256'(mem_address), 256'd0);
      check_eq("rst mem_wdata", mem_wdata, 256'd0);
      check_eq("rst dmd_resp", 256'(dmd_resp), 256'd0);
      check_eq("rst pf_resp", 256'(pf_resp), 256'd0);
      step();
      rst = 1'b0;

      // Lone demand read, latency 3
      step();
      lat = 3;
      dmd_read = 1'b1;
      dmd_address = 32'h0000_1234;
      sample();
      check_eq("lone c0 mem_read", 256'(mem_read), 256'd0);
      step();
      sample();
      check_eq("lone c1 mem_read", 256'(mem_read), 256'd1);
      check_eq("lone c1 mem_address", 256'(mem_address), 256'h0000_1220);
      check_eq("lone c1 state", 256'(dbg_state), 256'(S_DMD));
      wait_resp("lone resp", 1'b0, n);
      check_eq("lone resp cycle", 256'(n), 256'd3);
      check_eq("lone rdata", dmd_rdata, line_data(32'h0000_1220));
      check_eq("lone pf_resp", 256'(pf_resp), 256'd0);
      step();
      dmd_read = 1'b0;
      sample();
      check_eq("lone after state", 256'(dbg_state), 256'(S_IDLE));
      check_eq("lone after mem_read", 256'(mem_read), 256'd0);
      check_eq("lone after dmd_resp", 256'(dmd_resp), 256'd0);

      // Simultaneous requests: demand first, prefetch after one IDLE cycle
      step();
      lat = 2;
      dmd_read = 1'b1;
      dmd_address = 32'h0000_2000;
      pf_read = 1'b1;
      pf_address = 32'h0000_3010;
      step();
      sample();
      check_eq("simul state dmd", 256'(dbg_state), 256'(S_DMD));
      check_eq("simul defer 1", 256'(dbg_defer), 256'd1);
      check_eq("simul dmd addr", 256'(mem_address), 256'h0000_2000);
      wait_resp("simul dmd resp", 1'b0, n);
      check_eq("simul dmd rdata", dmd_rdata, line_data(32'h0000_2000));
      check_eq("simul pf_resp early", 256'(pf_resp), 256'd0);
      step();
      dmd_read = 1'b0;
      sample();
      check_eq("simul idle gap", 256'(dbg_state), 256'(S_IDLE));
      step();
      sample();
      check_eq("simul state pf", 256'(dbg_state), 256'(S_PF));
      check_eq("simul pf addr", 256'(mem_address), 256'h0000_3000);
      check_eq("simul pf defer 0", 256'(dbg_defer), 256'd0);
      wait_resp("simul pf resp", 1'b1, n);
      check_eq("simul pf rdata", pf_rdata, line_data(32'h0000_3000));
      check_eq("simul dmd_resp in pf", 256'(dmd_resp), 256'd0);
      step();
      pf_read = 1'b0;
      sample();

      // Starvation: 4 demand grants, then prefetch forced through
      step();
      lat = 1;
      dmd_read = 1'b1;
      dmd_address = 32'h0000_4020;
      pf_read = 1'b1;
      pf_address = 32'h0000_5000;
      exp_q.push_back(line_data(32'h0000_4020));
      for (int g = 1; g <= MAX_DEFER; g++) begin
         step();
         sample();
         check_eq($sformatf("starve grant%0d state", g), 256'(dbg_state), 256'(S_DMD));
         check_eq($sformatf("starve grant%0d defer", g), 256'(dbg_defer), 256'(g));
         wait_resp("starve dmd resp", 1'b0, n);
         check_eq($sformatf("starve grant%0d rdata", g), dmd_rdata, exp_q.pop_front());
         step();
         dmd_address = 32'h0000_4000 + 32'((g + 1) * 32'h20);
         exp_q.push_back(line_data(dmd_address));
         sample();
         check_eq($sformatf("starve idle%0d", g), 256'(dbg_state), 256'(S_IDLE));
      end
      step();
      sample();
      check_eq("starve forced pf", 256'(dbg_state), 256'(S_PF));
      check_eq("starve pf addr", 256'(mem_address), 256'h0000_5000);
      check_eq("starve defer clear", 256'(dbg_defer), 256'd0);
      wait_resp("starve pf resp", 1'b1, n);
      check_eq("starve pf rdata", pf_rdata, line_data(32'h0000_5000));
      check_eq("starve no dmd resp", 256'(dmd_resp), 256'd0);
      step();
      pf_read = 1'b0;
      sample();
      check_eq("starve idle after pf", 256'(dbg_state), 256'(S_IDLE));
      step();
      sample();
      check_eq("starve last dmd", 256'(dbg_state), 256'(S_DMD));
      wait_resp("starve last resp", 1'b0, n);
      check_eq("starve last rdata", dmd_rdata, exp_q.pop_front());
      step();
      dmd_read = 1'b0;
      sample();

      // Forwarding: demand read hits the in-flight prefetch line
      step();
      lat = 4;
      pf_read = 1'b1;
      pf_address = 32'h8000_0040;
      step();
      sample();
      check_eq("fwd state pf", 256'(dbg_state), 256'(S_PF));
      check_eq("fwd mem addr", 256'(mem_address), 256'h8000_0040);
      acc0 = mem_accesses;
      step();
      dmd_read = 1'b1;
      dmd_address = 32'h8000_0050;
      sample();
      check_eq("fwd early dmd_resp", 256'(dmd_resp), 256'd0);
      wait_resp("fwd pf resp", 1'b1, n);
      check_eq("fwd dmd_resp", 256'(dmd_resp), 256'd1);
      check_eq("fwd pulse", 256'(pf_forwarded), 256'd1);
      check_eq("fwd dmd rdata", dmd_rdata, line_data(32'h8000_0040));
      check_eq("fwd pf rdata", pf_rdata, line_data(32'h8000_0040));
      step();
      dmd_read = 1'b0;
      pf_read = 1'b0;
      sample();
      check_eq("fwd pulse drop", 256'(pf_forwarded), 256'd0);
      check_eq("fwd idle", 256'(dbg_state), 256'(S_IDLE));
      step();
      step();
      sample();
      check_eq("fwd no regrant", 256'(mem_read), 256'd0);
      check_eq("fwd single access", 256'(mem_accesses - acc0), 256'd0);

      // Write (with read also high) to the in-flight prefetch line: no forward
      step();
      lat = 2;
      pf_read = 1'b1;
      pf_address = 32'h8000_0040;
      step();
      sample();
      check_eq("wr state pf", 256'(dbg_state), 256'(S_PF));
      step();
      wd = {8{32'hDEAD_BEEF}} ^ {32'h1111_2222, 224'd0};
      dmd_write = 1'b1;
      dmd_read = 1'b1;
      dmd_address = 32'h8000_0048;
      dmd_wdata = wd;
      wait_resp("wr pf resp", 1'b1, n);
      check_eq("wr no dmd_resp", 256'(dmd_resp), 256'd0);
      check_eq("wr no fwd", 256'(pf_forwarded), 256'd0);
      step();
      pf_read = 1'b0;
      sample();
      check_eq("wr idle gap", 256'(dbg_state), 256'(S_IDLE));
      check_eq("wr idle mem_write", 256'(mem_write), 256'd0);
      step();
      sample();
      check_eq("wr state dmd", 256'(dbg_state), 256'(S_DMD));
      check_eq("wr mem_write", 256'(mem_write), 256'd1);
      check_eq("wr mem_read", 256'(mem_read), 256'd0);
      check_eq("wr mem_wdata", mem_wdata, wd);
      check_eq("wr mem_address", 256'(mem_address), 256'h8000_0040);
      wait_resp("wr dmd resp", 1'b0, n);
      check_eq("wr resp pf quiet", 256'(pf_resp), 256'd0);
      step();
      dmd_write = 1'b0;
      dmd_read = 1'b0;
      sample();
      check_eq("wr done idle", 256'(dbg_state), 256'(S_IDLE));

      // Spurious mem_resp in IDLE
      step();
      #1;
      mem_resp = 1'b1;
      sample();
      check_eq("spur dmd_resp", 256'(dmd_resp), 256'd0);
      check_eq("spur pf_resp", 256'(pf_resp), 256'd0);
      step();
      sample();
      check_eq("spur state", 256'(dbg_state), 256'(S_IDLE));
      check_eq("spur mem_read", 256'(mem_read), 256'd0);

      // Reset during a demand read with a defer count pending
      step();
      lat = 5;
      dmd_read = 1'b1;
      dmd_address = 32'h0000_6000;
      pf_read = 1'b1;
      pf_address = 32'h0000_7000;
      step();
      sample();
      check_eq("rstop mem_read", 256'(mem_read), 256'd1);
      check_eq("rstop defer", 256'(dbg_defer), 256'd1);
      step();
      rst = 1'b1;
      sample();
      check_eq("rstop dmd_resp in rst", 256'(dmd_resp), 256'd0);
      step();
      rst = 1'b0;
      dmd_read = 1'b0;
      pf_read = 1'b0;
      sample();
      check_eq("rstop after mem_read", 256'(mem_read), 256'd0);
      check_eq("rstop after state", 256'(dbg_state), 256'(S_IDLE));
      check_eq("rstop after defer", 256'(dbg_defer), 256'd0);
      check_eq("rstop after dmd_resp", 256'(dmd_resp), 256'd0);
      check_eq("rstop after pf_resp", 256'(pf_resp), 256'd0);
      repeat (6) begin
         step();
         sample();
         check_eq("rstop quiet resp", 256'({dmd_resp, pf_resp, mem_read}), 256'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
